// File: rtl/gate_test_pkg.sv
// Shared constants for the gate self-test engine: FSM state encoding and
// the reference truth tables of the 2-input library cells.
package gate_test_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        SHIFT  = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Bit k is the gate output for input vector k = {input2, input1}.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_table_checker_settle_counter.sv
// Settle-time up-counter: a load starts the count at 1, o_hit flags that the
// count has reached SETTLE_CYCLES.
module settle_counter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_inc,
    output logic o_hit
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(1);
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == CNT_W'(SETTLE_CYCLES));

endmodule

// File: rtl/gate_truth_table_checker.sv
// Truth-table checker for a 2-input gate: walks the four input vectors,
// captures the gate result after a settle time, shifts it out and grades it.
module gate_truth_table_checker
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] expected,
    input  logic       dut_result,
    output logic       dut_input1,
    output logic       dut_input2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] table_out,
    output logic       ser_out
);

    state_e     r_state;
    logic [1:0] r_k;
    logic       r_in1;
    logic       r_in2;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_table;
    logic       r_ser;

    logic       w_hit;
    logic       w_load;
    logic       w_inc;
    logic       w_clr;
    logic [1:0] w_k_nxt;

    assign w_k_nxt = r_k + 2'd1;
    assign w_load  = ((r_state == IDLE) && start) ||
                     ((r_state == SAMPLE) && (r_k != 2'd3));
    assign w_inc   = (r_state == SETTLE) && !w_hit;
    assign w_clr   = (r_state == DONE);

    settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_load  (w_load),
        .i_inc   (w_inc),
        .o_hit   (w_hit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_k     <= 2'd0;
            r_in1   <= 1'b0;
            r_in2   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_table <= 4'd0;
            r_ser   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_k     <= 2'd0;
                        r_in1   <= 1'b0;
                        r_in2   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_table <= 4'd0;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_hit) r_state <= SAMPLE;
                end
                SAMPLE: begin
                    r_table[r_k] <= dut_result;
                    if (r_k != 2'd3) begin
                        r_k            <= w_k_nxt;
                        {r_in2, r_in1} <= w_k_nxt;
                        r_state        <= SETTLE;
                    end else begin
                        // r_k is reused as the shift index; bit 0 goes out first.
                        r_k     <= 2'd0;
                        r_ser   <= r_table[0];
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_k == 2'd3) begin
                        r_ser   <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_ser <= r_table[w_k_nxt];
                        r_k   <= w_k_nxt;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_pass  <= (r_table == expected);
                    r_busy  <= 1'b0;
                    r_in1   <= 1'b0;
                    r_in2   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dut_input1 = r_in1;
    assign dut_input2 = r_in2;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign table_out  = r_table;
    assign ser_out    = r_ser;

endmodule
